float_add_seq: RTL and testbench

Multi-cycle sequencer that performs the 8-bit minifloat addition (3-bit exponent, 5-bit mantissa) as explicit, registered steps: compare, align, add, normalize. It accepts one operand pair through a valid/ready handshake and presents the sum through a second valid/ready handshake. It is the sequential controller around the float adder datapath, giving the downstream pipeline a deterministic, back-pressurable adder.

---
 rtl/float_add_seq.sv | 100 ++++++++++
 tb/tb_float_add_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/float_add_seq.sv
// rtl/float_add_seq.sv - multi-cycle 8-bit minifloat adder (3-bit exp, 5-bit mant)
// Steps through compare, align, add and normalize with valid/ready on both sides.
`timescale 1ns/1ps
module float_add_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       overflow
);

  typedef enum logic [2:0] {IDLE, CMP, ALIGN, ADD, NORM, DONE} state_t;

  state_t     state;
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic [2:0] big_exp;
  logic [4:0] big_mant;
  logic [4:0] small_mant;
  logic [2:0] shift_cnt;
  logic [5:0] sum;

  logic       a_big;
  logic [2:0] exp_diff;

  // A wins ties so the choice is deterministic on identical operands.
  always_comb begin
    a_big    = (a_reg[7:5] > b_reg[7:5]) ||
               ((a_reg[7:5] == b_reg[7:5]) && (a_reg[4:0] >= b_reg[4:0]));
    exp_diff = a_big ? (a_reg[7:5] - b_reg[7:5]) : (b_reg[7:5] - a_reg[7:5]);
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      a_reg      <= 8'h00;
      b_reg      <= 8'h00;
      big_exp    <= 3'd0;
      big_mant   <= 5'd0;
      small_mant <= 5'd0;
      shift_cnt  <= 3'd0;
      sum        <= 6'd0;
      result     <= 8'h00;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a_in;
            b_reg <= b_in;
            state <= CMP;
          end
        end
        CMP: begin
          big_exp    <= a_big ? a_reg[7:5] : b_reg[7:5];
          big_mant   <= a_big ? a_reg[4:0] : b_reg[4:0];
          small_mant <= a_big ? b_reg[4:0] : a_reg[4:0];
          // Beyond five shifts the 5-bit mantissa is already all zeros.
          shift_cnt  <= (exp_diff > 3'd5) ? 3'd5 : exp_diff;
          state      <= (exp_diff != 3'd0) ? ALIGN : ADD;
        end
        ALIGN: begin
          small_mant <= small_mant >> 1;
          shift_cnt  <= shift_cnt - 3'd1;
          if (shift_cnt == 3'd1) state <= ADD;
        end
        ADD: begin
          sum   <= {1'b0, big_mant} + {1'b0, small_mant};
          state <= NORM;
        end
        NORM: begin
          if (!sum[5]) begin
            result   <= {big_exp, sum[4:0]};
            overflow <= 1'b0;
          end else if (big_exp != 3'd7) begin
            result   <= {big_exp + 3'd1, sum[5:1]};
            overflow <= 1'b0;
          end else begin
            result   <= 8'hFF;
            overflow <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_add_seq.sv
// tb/tb_float_add_seq.sv - self-checking bench for float_add_seq
// Directed and random operand pairs against an arithmetic reference model.
`timescale 1ns/1ps
module tb_float_add_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       overflow;

  int checks = 0;
  int passed = 0;

  float_add_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: value = mantissa at exponent scale, smaller operand truncated
  // by the (capped) exponent gap, carry bumps the exponent or saturates.
  function automatic void ref_add(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic ov, output int lat);
    int ae, am, be, bm, hi_e, hi_m, lo_e, lo_m, d, s;
    ae = int'(a[7:5]); am = int'(a[4:0]);
    be = int'(b[7:5]); bm = int'(b[4:0]);
    if (ae > be || (ae == be && am >= bm)) begin
      hi_e = ae; hi_m = am; lo_e = be; lo_m = bm;
    end else begin
      hi_e = be; hi_m = bm; lo_e = ae; lo_m = am;
    end
    d = hi_e - lo_e;
    if (d > 5) d = 5;
    s = hi_m + lo_m / (1 << d);
    ov = 1'b0;
    if (s < 32) r = 8'(hi_e * 32 + s);
    else if (hi_e < 7) r = 8'((hi_e + 1) * 32 + s / 2);
    else begin
      r = 8'hFF; ov = 1'b1;
    end
    lat = 3 + d;
  endfunction

  task automatic do_accept(input logic [7:0] a, input logic [7:0] b);
    int n;
    @(negedge clk);
    a_in = a; b_in = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    a_in = 8'($urandom);
    b_in = 8'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] er;
    logic       eo;
    int         el, lat;
    ref_add(a, b, er, eo, el);
    do_accept(a, b);
    wait_done(lat);
    check({tag, "_result"}, result, er);
    check({tag, "_overflow"}, overflow, eo);
    check({tag, "_latency"}, lat, el);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
    check({tag, "_hold"}, result, er);
  endtask

  initial begin
    logic [7:0] er1, er2;
    logic       eo1, eo2;
    int         el1, el2, lat;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = 8'h00; b_in = 8'h00;
    #2;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result", result, 8'h00);
    check("reset_overflow", overflow, 1'b0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;

    run_op("eq_exp", 8'h28, 8'h24);
    run_op("carry", 8'h3F, 8'h21);
    run_op("align_ab", 8'h70, 8'h28);
    run_op("align_ba", 8'h28, 8'h70);
    run_op("shift_cap", 8'hF0, 8'h1F);
    run_op("saturate", 8'hFF, 8'hE1);
    run_op("zero", 8'h00, 8'h00);

    // Back-pressure: junk operands with in_valid high while DONE is stalled.
    ref_add(8'h70, 8'h28, er1, eo1, el1);
    ref_add(8'h3F, 8'h21, er2, eo2, el2);
    do_accept(8'h70, 8'h28);
    wait_done(lat);
    check("bp_first_latency", lat, el1);
    for (int i = 0; i < 4; i++) begin
      a_in = 8'($urandom); b_in = 8'($urandom); in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_result", result, er1);
    end
    a_in = 8'h3F; b_in = 8'h21; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_idle", {out_valid, in_ready}, 2'b01);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_accepted", in_ready, 1'b0);
    wait_done(lat);
    check("bp_second_result", result, er2);
    check("bp_second_latency", lat, el2);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Reset while in ALIGN: must clear without a clock edge.
    do_accept(8'h70, 8'h28);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_in_ready", in_ready, 1'b1);
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_result", result, 8'h00);
    check("rst_mid_overflow", overflow, 1'b0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    run_op("after_reset", 8'h70, 8'h28);

    for (int i = 0; i < 40; i++) begin
      run_op("random", 8'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
